// File: rtl/branch_resolve_queue.sv
// In-order queue of outstanding predicted branches. Emits a registered training
// update per resolution and squashes wrong-path entries on a mispredict.
module branch_resolve_queue #(
    parameter int PC_W  = 8,
    parameter int GHR_W = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    input  logic [PC_W-1:0]            alloc_pc,
    input  logic                       alloc_pred,
    input  logic [GHR_W-1:0]           alloc_ghr,
    input  logic                       resolve_valid,
    output logic                       resolve_ready,
    input  logic                       resolve_taken,
    output logic                       upd_valid,
    output logic [PC_W-1:0]            upd_pc,
    output logic [GHR_W-1:0]           upd_ghr,
    output logic                       upd_taken,
    output logic                       upd_mispredict,
    output logic                       flush_valid,
    output logic [GHR_W-1:0]           flush_ghr,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [31:0]                resolved_count,
    output logic [31:0]                mispredict_count
);
    // Handshake: a transfer fires on a rising edge where valid & ready are both high;
    // ready is a function of registered state only, never of the matching valid.
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);
    localparam logic [OW-1:0] OCC_ONE  = OW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [PC_W-1:0]  mem_pc   [DEPTH];
    logic             mem_pred [DEPTH];
    logic [GHR_W-1:0] mem_ghr  [DEPTH];

    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic             upd_valid_q, flush_valid_q;
    logic [PC_W-1:0]  upd_pc_q;
    logic [GHR_W-1:0] upd_ghr_q, flush_ghr_q;
    logic             upd_taken_q, upd_mis_q;
    logic [31:0]      res_cnt_q, mis_cnt_q;

    logic             alloc_fire, resolve_fire, mispred;
    logic [AW-1:0]    head_inc;

    assign alloc_ready   = (occ_q != OCC_FULL);
    assign resolve_ready = (occ_q != '0);
    assign alloc_fire    = alloc_valid & alloc_ready;
    assign resolve_fire  = resolve_valid & resolve_ready;
    assign mispred       = resolve_taken != mem_pred[head_q];
    assign head_inc      = head_q + PTR_ONE;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (resolve_fire && mispred) begin
            // Everything younger than the mispredicted branch, including a
            // same-cycle allocation, is wrong-path and is dropped.
            head_d = head_inc;
            tail_d = head_inc;
            occ_d  = '0;
        end else begin
            if (resolve_fire) head_d = head_inc;
            if (alloc_fire)   tail_d = tail_q + PTR_ONE;
            if (alloc_fire && !resolve_fire)      occ_d = occ_q + OCC_ONE;
            else if (!alloc_fire && resolve_fire) occ_d = occ_q - OCC_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && alloc_fire) begin
            mem_pc[tail_q]   <= alloc_pc;
            mem_pred[tail_q] <= alloc_pred;
            mem_ghr[tail_q]  <= alloc_ghr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q        <= '0;
            tail_q        <= '0;
            occ_q         <= '0;
            upd_valid_q   <= 1'b0;
            upd_pc_q      <= '0;
            upd_ghr_q     <= '0;
            upd_taken_q   <= 1'b0;
            upd_mis_q     <= 1'b0;
            flush_valid_q <= 1'b0;
            flush_ghr_q   <= '0;
            res_cnt_q     <= '0;
            mis_cnt_q     <= '0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            occ_q         <= occ_d;
            upd_valid_q   <= resolve_fire;
            flush_valid_q <= resolve_fire & mispred;
            if (resolve_fire) begin
                upd_pc_q    <= mem_pc[head_q];
                upd_ghr_q   <= mem_ghr[head_q];
                upd_taken_q <= resolve_taken;
                upd_mis_q   <= mispred;
                flush_ghr_q <= {mem_ghr[head_q][GHR_W-2:0], resolve_taken};
                if (res_cnt_q != '1) res_cnt_q <= res_cnt_q + 32'd1;
                if (mispred && mis_cnt_q != '1) mis_cnt_q <= mis_cnt_q + 32'd1;
            end
        end
    end

    assign occupancy        = occ_q;
    assign upd_valid        = upd_valid_q;
    assign upd_pc           = upd_pc_q;
    assign upd_ghr          = upd_ghr_q;
    assign upd_taken        = upd_taken_q;
    assign upd_mispredict   = upd_mis_q;
    assign flush_valid      = flush_valid_q;
    assign flush_ghr        = flush_ghr_q;
    assign resolved_count   = res_cnt_q;
    assign mispredict_count = mis_cnt_q;
endmodule
